// File: rtl/mul_pipe_pkg.sv
// Shared widths and narrowing helpers for mul_pipe_nstage.
// MUL_PIPE_SAT_EN (in the lane) selects saturating narrowing via sat_narrow().
package mul_pipe_pkg;

   localparam int BNN_DIN0_W = 30;
   localparam int BNN_DIN1_W = 11;
   localparam int BNN_DOUT_W = 30;
   localparam int MAXW       = 128;

   function automatic int prod_width(input int w0, input int w1);
      return w0 + w1;
   endfunction

   // Returns {ovf, clamped}; value arrives already extended to MAXW bits.
   function automatic logic [MAXW:0] sat_narrow(input logic [MAXW-1:0] value,
                                                input logic            is_signed,
                                                input int              pw,
                                                input int              dw);
      logic [MAXW-1:0] one, hi, lo, res;
      logic            ov;
      one = MAXW'(1);
      hi  = '0;
      lo  = '0;
      res = value;
      ov  = 1'b0;
      if (dw < pw) begin
         if (is_signed) begin
            hi = (one << (dw - 1)) - one;
            lo = ~hi;
            if ($signed(value) > $signed(hi)) begin
               res = hi;
               ov  = 1'b1;
            end else if ($signed(value) < $signed(lo)) begin
               res = lo;
               ov  = 1'b1;
            end
         end else begin
            hi = (one << dw) - one;
            if (value > hi) begin
               res = hi;
               ov  = 1'b1;
            end
         end
      end
      return {ov, res};
   endfunction

endpackage

// File: rtl/mul_pipe_lane.sv
// One multiplier lane: operand registers, exact multiply, product delay chain, narrowing.
// With MUL_PIPE_SAT_EN defined the narrowing saturates and reports ovf; otherwise it wraps.
module mul_pipe_lane
   import mul_pipe_pkg::*;
#(
   parameter int NUM_STAGE   = 2,
   parameter int DIN0_WIDTH  = BNN_DIN0_W,
   parameter int DIN1_WIDTH  = BNN_DIN1_W,
   parameter int DOUT_WIDTH  = BNN_DOUT_W,
   parameter int DIN0_SIGNED = 1,
   parameter int DIN1_SIGNED = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ce,
   input  logic [DIN0_WIDTH-1:0] din0,
   input  logic [DIN1_WIDTH-1:0] din1,
   output logic [DOUT_WIDTH-1:0] dout,
   output logic                  ovf
);

   localparam int P          = prod_width(DIN0_WIDTH, DIN1_WIDTH);
   localparam bit S0         = (DIN0_SIGNED != 0);
   localparam bit S1         = (DIN1_SIGNED != 0);
   localparam bit RES_SIGNED = S0 || S1;

   if (P >= MAXW || DOUT_WIDTH > MAXW) begin : g_width_chk
      $error("mul_pipe_lane: operand/result width exceeds MAXW");
   end

   // Both operands widened to P bits so a signed P-bit multiply is exact.
   function automatic logic [P-1:0] mul_full(input logic [DIN0_WIDTH-1:0] a,
                                             input logic [DIN1_WIDTH-1:0] b);
      logic signed [P-1:0] ae, be;
      ae = {{(P-DIN0_WIDTH){a[DIN0_WIDTH-1] & S0}}, a};
      be = {{(P-DIN1_WIDTH){b[DIN1_WIDTH-1] & S1}}, b};
      return P'(ae * be);
   endfunction

   function automatic logic [DOUT_WIDTH:0] narrow(input logic [P-1:0] p);
      logic [MAXW-1:0] wide;
      logic [MAXW:0]   r;
      wide = {{(MAXW-P){RES_SIGNED & p[P-1]}}, p};
`ifdef MUL_PIPE_SAT_EN
      r = sat_narrow(wide, RES_SIGNED, P, DOUT_WIDTH);
`else
      r = {1'b0, wide};
`endif
      return {r[MAXW], r[DOUT_WIDTH-1:0]};
   endfunction

   logic [P-1:0]          last_prod;
   logic [DOUT_WIDTH-1:0] dout_q, dout_d;
   logic                  ovf_q, ovf_d;

   if (NUM_STAGE == 1) begin : g_comb
      assign last_prod = mul_full(din0, din1);
   end else begin : g_reg
      logic [DIN0_WIDTH-1:0] a_q, a_d;
      logic [DIN1_WIDTH-1:0] b_q, b_d;

      always_comb begin
         a_d = a_q;
         b_d = b_q;
         if (ce) begin
            a_d = din0;
            b_d = din1;
         end
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            a_q <= '0;
            b_q <= '0;
         end else begin
            a_q <= a_d;
            b_q <= b_d;
         end
      end

      if (NUM_STAGE == 2) begin : g_nodly
         assign last_prod = mul_full(a_q, b_q);
      end else begin : g_dly
         logic [NUM_STAGE-3:0][P-1:0] prod_q, prod_d;

         always_comb begin
            prod_d = prod_q;
            if (ce) begin
               prod_d[0] = mul_full(a_q, b_q);
               for (int k = 1; k < NUM_STAGE - 2; k++) prod_d[k] = prod_q[k-1];
            end
         end

         always_ff @(posedge clk) begin
            if (reset) prod_q <= '0;
            else       prod_q <= prod_d;
         end

         assign last_prod = prod_q[NUM_STAGE-3];
      end
   end

   always_comb begin
      dout_d = dout_q;
      ovf_d  = ovf_q;
      if (ce) {ovf_d, dout_d} = narrow(last_prod);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         dout_q <= '0;
         ovf_q  <= 1'b0;
      end else begin
         dout_q <= dout_d;
         ovf_q  <= ovf_d;
      end
   end

   assign dout = dout_q;
   assign ovf  = ovf_q;

endmodule

// File: rtl/mul_pipe_nstage.sv
// LANES-wide pipelined multiplier with a shared valid shift register frozen by ce.
// MUL_PIPE_SAT_EN enables saturating narrowing with per-lane ovf inside mul_pipe_lane.
module mul_pipe_nstage
   import mul_pipe_pkg::*;
#(
   parameter int ID          = 1,
   parameter int LANES       = 4,
   parameter int NUM_STAGE   = 2,
   parameter int DIN0_WIDTH  = BNN_DIN0_W,
   parameter int DIN1_WIDTH  = BNN_DIN1_W,
   parameter int DOUT_WIDTH  = BNN_DOUT_W,
   parameter int DIN0_SIGNED = 1,
   parameter int DIN1_SIGNED = 0
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        ce,
   input  logic                        in_valid,
   input  logic [LANES*DIN0_WIDTH-1:0] din0,
   input  logic [LANES*DIN1_WIDTH-1:0] din1,
   output logic [LANES*DOUT_WIDTH-1:0] dout,
   output logic                        out_valid,
   output logic [LANES-1:0]            ovf
);

   if (LANES < 1 || NUM_STAGE < 1 || ID < 0) begin : g_param_chk
      $error("mul_pipe_nstage: illegal parameter value");
   end

   logic [NUM_STAGE:1] vld_pipe_q, vld_pipe_d;
   logic [LANES-1:0]   lane_ovf;

   always_comb begin
      vld_pipe_d = vld_pipe_q;
      if (ce) begin
         vld_pipe_d[1] = in_valid;
         for (int s = 2; s <= NUM_STAGE; s++) vld_pipe_d[s] = vld_pipe_q[s-1];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) vld_pipe_q <= '0;
      else       vld_pipe_q <= vld_pipe_d;
   end

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      mul_pipe_lane #(
         .NUM_STAGE   (NUM_STAGE),
         .DIN0_WIDTH  (DIN0_WIDTH),
         .DIN1_WIDTH  (DIN1_WIDTH),
         .DOUT_WIDTH  (DOUT_WIDTH),
         .DIN0_SIGNED (DIN0_SIGNED),
         .DIN1_SIGNED (DIN1_SIGNED)
      ) u_lane (
         .clk   (clk),
         .reset (reset),
         .ce    (ce),
         .din0  (din0[i*DIN0_WIDTH +: DIN0_WIDTH]),
         .din1  (din1[i*DIN1_WIDTH +: DIN1_WIDTH]),
         .dout  (dout[i*DOUT_WIDTH +: DOUT_WIDTH]),
         .ovf   (lane_ovf[i])
      );
   end

   assign out_valid = vld_pipe_q[NUM_STAGE];
   // Clamp flags are only meaningful alongside a valid result.
   assign ovf = lane_ovf & {LANES{out_valid}};

endmodule
